// File: rtl/seg_pkg.sv
// Shared seven-segment definitions for the scan driver and the receive-side decoder.
package seg_pkg;

  localparam int unsigned SEG_W      = 7;
  localparam int unsigned SEL_W      = 4;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned NUM_DIGITS = 4;

  // Active-low abcdefg, bit 6 = a.
  localparam logic [SEG_W-1:0] SEG_CODE_0 = 7'b0000001;
  localparam logic [SEG_W-1:0] SEG_CODE_1 = 7'b1001111;
  localparam logic [SEG_W-1:0] SEG_CODE_2 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_CODE_3 = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_CODE_4 = 7'b1001100;
  localparam logic [SEG_W-1:0] SEG_CODE_5 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_CODE_6 = 7'b0100000;
  localparam logic [SEG_W-1:0] SEG_CODE_7 = 7'b0001111;
  localparam logic [SEG_W-1:0] SEG_CODE_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_CODE_9 = 7'b0000100;

  localparam logic [SEL_W-1:0] SEL_DIGIT0 = 4'b0111;
  localparam logic [SEL_W-1:0] SEL_DIGIT1 = 4'b1011;
  localparam logic [SEL_W-1:0] SEL_DIGIT2 = 4'b1101;
  localparam logic [SEL_W-1:0] SEL_DIGIT3 = 4'b1110;
  localparam logic [SEL_W-1:0] SEL_BLANK  = 4'b1111;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [SEG_W-1:0] seg;
  } scan_pair_t;

endpackage

// File: rtl/seg_pattern_to_bcd.sv
// Combinational lookup from an active-low segment pattern to its BCD digit.
module seg_pattern_to_bcd
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output logic [BCD_W-1:0] bcd_c_o,
  output logic             valid_c_o
);

  always_comb begin
    bcd_c_o   = '0;
    valid_c_o = 1'b1;
    case (pattern_i)
      SEG_CODE_0: bcd_c_o = 4'd0;
      SEG_CODE_1: bcd_c_o = 4'd1;
      SEG_CODE_2: bcd_c_o = 4'd2;
      SEG_CODE_3: bcd_c_o = 4'd3;
      SEG_CODE_4: bcd_c_o = 4'd4;
      SEG_CODE_5: bcd_c_o = 4'd5;
      SEG_CODE_6: bcd_c_o = 4'd6;
      SEG_CODE_7: bcd_c_o = 4'd7;
      SEG_CODE_8: bcd_c_o = 4'd8;
      SEG_CODE_9: bcd_c_o = 4'd9;
      default:    valid_c_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples a multiplexed seven-segment bus, filters changeover glitches and
// reassembles one four-digit BCD frame per scan cycle.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned STABLE  = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SEL_W-1:0]            select_in,
  input  logic [SEG_W-1:0]            seg_in,
  output logic [NUM_DIGITS*BCD_W-1:0] digits,
  output logic                        valid,
  output logic                        frame_done,
  output logic                        code_err,
  output logic                        sel_err,
  output logic                        stale
);

  localparam int unsigned DWELL_W = $clog2(STABLE + 1);
  localparam int unsigned IDLE_W  = $clog2(TIMEOUT + 1);

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] digit_vec_t;

  scan_pair_t         sync1_q, sync2_q, prev_q;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               taken_q, taken_d;
  logic               accept_c;

  logic [IDLE_W-1:0]     idle_q, idle_d;
  logic [NUM_DIGITS-1:0] mask_q, mask_d;
  digit_vec_t            staging_q, staging_d;
  digit_vec_t            digits_q, digits_d;
  logic                  valid_q, valid_d;
  logic                  frame_done_q, frame_done_d;
  logic                  code_err_q, code_err_d;
  logic                  sel_err_q, sel_err_d;
  logic                  stale_q, stale_d;

  logic [BCD_W-1:0] pat_bcd_c;
  logic             pat_ok_c;
  logic             sel_ok_c, sel_blank_c;
  logic [1:0]       pos_c;
  logic             complete_c, digit_ok_c;

  seg_pattern_to_bcd u_pattern (
    .pattern_i (sync2_q.seg),
    .bcd_c_o   (pat_bcd_c),
    .valid_c_o (pat_ok_c)
  );

  // Dwell filter: a pair is taken once, when its run first reaches STABLE.
  always_comb begin
    dwell_d  = dwell_q;
    taken_d  = taken_q;
    accept_c = 1'b0;
    if (sync2_q != prev_q) begin
      dwell_d = DWELL_W'(1);
      taken_d = 1'b0;
    end else if (dwell_q != DWELL_W'(STABLE)) begin
      dwell_d = dwell_q + DWELL_W'(1);
    end
    if ((dwell_d == DWELL_W'(STABLE)) && !taken_d) begin
      accept_c = 1'b1;
      taken_d  = 1'b1;
    end
  end

  always_comb begin
    sel_blank_c = (sync2_q.sel == SEL_BLANK);
    sel_ok_c    = 1'b1;
    pos_c       = 2'd0;
    case (sync2_q.sel)
      SEL_DIGIT0: pos_c = 2'd0;
      SEL_DIGIT1: pos_c = 2'd1;
      SEL_DIGIT2: pos_c = 2'd2;
      SEL_DIGIT3: pos_c = 2'd3;
      default:    sel_ok_c = 1'b0;
    endcase
  end

  // Frame assembly; completion takes priority over the idle timeout.
  always_comb begin
    mask_d       = mask_q;
    staging_d    = staging_q;
    idle_d       = idle_q;
    digits_d     = digits_q;
    valid_d      = valid_q;
    stale_d      = stale_q;
    frame_done_d = 1'b0;
    code_err_d   = 1'b0;
    sel_err_d    = 1'b0;
    digit_ok_c   = 1'b0;
    complete_c   = (mask_q == '1);

    if (complete_c) begin
      digits_d     = staging_q;
      frame_done_d = 1'b1;
      valid_d      = 1'b1;
      stale_d      = 1'b0;
      mask_d       = '0;
    end

    if (accept_c && !sel_blank_c) begin
      if (!sel_ok_c) begin
        sel_err_d = 1'b1;
      end else if (!pat_ok_c) begin
        code_err_d = 1'b1;
      end else begin
        staging_d[pos_c] = pat_bcd_c;
        mask_d[pos_c]    = 1'b1;
        digit_ok_c       = 1'b1;
      end
    end

    if (complete_c || digit_ok_c) begin
      idle_d = '0;
    end else if (idle_q != IDLE_W'(TIMEOUT)) begin
      idle_d = idle_q + IDLE_W'(1);
      if (idle_d == IDLE_W'(TIMEOUT)) begin
        stale_d = 1'b1;
        valid_d = 1'b0;
        mask_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      dwell_q      <= '0;
      taken_q      <= 1'b1;
      idle_q       <= '0;
      mask_q       <= '0;
      staging_q    <= '0;
      digits_q     <= '0;
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
      code_err_q   <= 1'b0;
      sel_err_q    <= 1'b0;
      stale_q      <= 1'b0;
    end else begin
      sync1_q      <= scan_pair_t'({select_in, seg_in});
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      dwell_q      <= dwell_d;
      taken_q      <= taken_d;
      idle_q       <= idle_d;
      mask_q       <= mask_d;
      staging_q    <= staging_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      code_err_q   <= code_err_d;
      sel_err_q    <= sel_err_d;
      stale_q      <= stale_d;
    end
  end

  assign digits     = digits_q;
  assign valid      = valid_q;
  assign frame_done = frame_done_q;
  assign code_err   = code_err_q;
  assign sel_err    = sel_err_q;
  assign stale      = stale_q;

endmodule
